// File: rtl/ahb_sram.sv
// ahb_sram: parametrised AHB-Lite SRAM slave.
//
// Word-organised memory of DEPTH x DATA_W bits. It has byte-lane writes
// selected by HSIZE/HADDR, programmable data-phase wait states, a two-cycle
// ERROR response for illegal accesses, and read-after-write forwarding.
//
// Build option:
//   AHB_SRAM_CLEAR_ON_RESET_EN - when defined, reset asynchronously zeroes
//   every memory word. When undefined, the contents survive reset, which
//   keeps the array inferable as block RAM.
module ahb_sram #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 17,
  parameter int              DEPTH       = 1024,
  parameter longint unsigned BASE_ADDR   = 0,
  parameter int              WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;

  localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
  localparam logic [63:0] END64  = 64'(BASE_ADDR) + 64'(DEPTH) * 64'(NB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               wr_q;
  logic [NB-1:0]      mask_q;
  logic [IDX_W-1:0]   idx_q;

  logic               hready_int;
  logic               accept;
  logic               take;
  logic               commit;

  logic [63:0]        addr64;
  logic [63:0]        offset;
  logic [63:0]        lane_off;
  logic [7:0]         size_bytes;
  logic [IDX_W-1:0]   word_idx;
  logic [NB-1:0]      lane_mask;
  logic               range_err;
  logic               size_err;
  logic               align_err;
  logic               req_err;
  logic [DATA_W-1:0]  rd_word;

  logic [DATA_W-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------
  // Address-phase decode of the incoming request
  // ---------------------------------------------------------------------
  assign addr64     = 64'(HADDR);
  assign offset     = addr64 - BASE64;
  assign lane_off   = offset & 64'(NB - 1);
  assign size_bytes = 8'd1 << HSIZE;
  assign word_idx   = IDX_W'(offset >> LB);

  assign range_err  = (addr64 < BASE64) || (addr64 >= END64);
  assign size_err   = ({29'd0, HSIZE} > 32'(LB));
  assign align_err  = (addr64 & (64'(size_bytes) - 64'd1)) != 64'd0;
  assign req_err    = range_err || size_err || align_err;

  // The bus sees our HREADYOUT as HREADY. Gating with our own ready keeps
  // the data-phase state intact even if HREADY is driven inconsistently.
  assign accept = HSEL && HTRANS[1] && HREADY;
  assign take   = accept && hready_int;

  // The write data phase ends, and HWDATA is committed, on the last data cycle.
  assign commit = (state == ST_DATA) && (cnt == '0) && wr_q;

  // Byte lanes covered by 2^HSIZE bytes starting at the addressed lane.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if ((64'(i) >= lane_off) && (64'(i) < lane_off + 64'(size_bytes)))
        lane_mask[i] = 1'b1;
    end
  end

  // Read word with forwarding of a write committing to the same word this edge.
  always_comb begin
    rd_word = mem[word_idx];
    if (commit && (idx_q == word_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b])
          rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transfer state machine
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge HCLK or negedge HRESET) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values; combinational blocks use blocking assignments.
    if (!HRESET)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  // Next state and the slave response outputs.
  always_comb begin
    state_d    = state;
    hready_int = 1'b1;
    HRESP      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take)
          state_d = req_err ? ST_ERR1 : ST_DATA;
      end
      ST_DATA: begin
        hready_int = (cnt == '0);
        if (cnt == '0) begin
          if (take)
            state_d = req_err ? ST_ERR1 : ST_DATA;
          else
            state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hready_int = 1'b0;
        HRESP      = 1'b1;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
        if (take)
          state_d = req_err ? ST_ERR1 : ST_DATA;
        else
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign HREADYOUT = hready_int;

  // Latch the accepted request and run the wait-state counter.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      cnt    <= '0;
      wr_q   <= 1'b0;
      mask_q <= '0;
      idx_q  <= '0;
    end else if (take) begin
      cnt    <= req_err ? '0 : CNT_W'(WAIT_STATES);
      wr_q   <= HWRITE && !req_err;
      mask_q <= lane_mask;
      idx_q  <= word_idx;
    end else if ((state == ST_DATA) && (cnt != '0)) begin
      cnt    <= cnt - 1'b1;
    end
  end

  // Registered read data, loaded only by accepted legal reads.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET)
      HRDATA <= '0;
    else if (take && !req_err && !HWRITE)
      HRDATA <= rd_word;
  end

  // ---------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------
`ifdef AHB_SRAM_CLEAR_ON_RESET_EN
  // Byte-lane write port with asynchronous clear of every word.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b])
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end
`else
  // Byte-lane write port.
  always_ff @(posedge HCLK) begin
    // NOTE: the array has no reset so it can map onto block RAM; only the
    // control path and outputs are reset.
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b])
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_sram.sv
// tb_ahb_sram: self-checking bench for ahb_sram.
// Two instances: a default one (base 0, zero wait) and a wait-stated one
// (base 0x1000, 64 words, 2 wait states). They share the address and data
// signals and are selected by their own HSEL. A byte-addressed model gives
// every expected value.
module tb_ahb_sram;

  localparam int          WS_WAIT = 2;
  localparam logic [16:0] WS_BASE = 17'h01000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        bus_sel;
  logic        use_ws;
  logic [16:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;

  logic        m_sel, w_sel;
  logic        m_ready, m_resp, w_ready, w_resp;
  logic [31:0] m_rdata, w_rdata;
  logic        act_ready, act_resp;
  logic [31:0] act_rdata;

  assign m_sel     = bus_sel & ~use_ws;
  assign w_sel     = bus_sel & use_ws;
  assign act_ready = use_ws ? w_ready : m_ready;
  assign act_resp  = use_ws ? w_resp  : m_resp;
  assign act_rdata = use_ws ? w_rdata : m_rdata;

  ahb_sram u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(m_sel), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(m_ready), .HREADYOUT(m_ready), .HRESP(m_resp), .HRDATA(m_rdata)
  );

  ahb_sram #(.DEPTH(64), .BASE_ADDR(64'h1000), .WAIT_STATES(WS_WAIT)) u_dut_ws (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(w_sel), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(w_ready), .HREADYOUT(w_ready), .HRESP(w_resp), .HRDATA(w_rdata)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Byte-addressed reference memories (offset from each instance's base).
  logic [7:0]  mdl_m [4096];
  logic [7:0]  mdl_w [256];
  logic [31:0] exp_rd [2];

  // Transfer whose data phase is in progress.
  logic        pend_valid = 1'b0;
  logic        pend_err   = 1'b0;
  int          pend_stalls = 0;
  logic [31:0] pend_wdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic ws, input logic [16:0] a, input logic [2:0] sz);
    int unsigned ua     = 32'(a);
    int unsigned base   = ws ? 32'h1000 : 32'h0;
    int unsigned words  = ws ? 32'd64 : 32'd1024;
    int unsigned nbytes = 32'd1 << sz;
    return (ua < base) || (ua >= base + words * 4) || (nbytes > 4) || ((ua % nbytes) != 0);
  endfunction

  task automatic model_write(input logic ws, input logic [16:0] a, input logic [2:0] sz,
                             input logic [31:0] wdata);
    int unsigned off = 32'(a) - (ws ? 32'h1000 : 32'h0);
    for (int b = 0; b < (1 << sz); b++) begin
      int unsigned ln = (off + b) % 4;
      if (ws) mdl_w[off + b] = wdata[8*ln +: 8];
      else    mdl_m[off + b] = wdata[8*ln +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic ws, input logic [16:0] a);
    int unsigned w = (32'(a) - (ws ? 32'h1000 : 32'h0)) & ~32'd3;
    if (ws) return {mdl_w[w+3], mdl_w[w+2], mdl_w[w+1], mdl_w[w]};
    return {mdl_m[w+3], mdl_m[w+2], mdl_m[w+1], mdl_m[w]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) mdl_m[i] = 8'h00;
    for (int i = 0; i < 256; i++)  mdl_w[i] = 8'h00;
  endtask

  // Drive one address phase (sel=0 gives IDLE) alongside the previous
  // transfer's write data. Wait until it is accepted, then check the first
  // data-phase cycle. Called and returns at a falling edge.
  task automatic issue(input logic sel, input logic wr, input logic [16:0] a,
                       input logic [2:0] sz, input logic [31:0] wdata);
    int   stalls;
    logic err;
    bus_sel = sel;
    HTRANS  = sel ? 2'b10 : 2'b00;
    HADDR   = a;
    HSIZE   = sz;
    HWRITE  = wr;
    HWDATA  = pend_wdata;
    stalls  = 0;
    while (act_ready !== 1'b1 && stalls < 16) begin
      check("rdata_hold", act_rdata, exp_rd[use_ws]);
      @(posedge HCLK); @(negedge HCLK);
      stalls++;
    end
    if (pend_valid) begin
      check("stall_cycles", 32'(stalls), 32'(pend_stalls));
      if (pend_err) check("err2_resp", 32'(act_resp), 32'd1);
    end
    @(posedge HCLK); @(negedge HCLK);
    err         = sel && is_err(use_ws, a, sz);
    pend_valid  = sel;
    pend_err    = err;
    pend_wdata  = wdata;
    pend_stalls = err ? 1 : (use_ws ? WS_WAIT : 0);
    if (sel && !err) begin
      if (wr) model_write(use_ws, a, sz, wdata);
      else    exp_rd[use_ws] = model_read(use_ws, a);
    end
    check("resp", 32'(act_resp), 32'(err));
    check("ready", 32'(act_ready), (sel && (err || use_ws)) ? 32'd0 : 32'd1);
    check("rdata", act_rdata, exp_rd[use_ws]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] a;
    logic [2:0]  sz;
    int          kind;

    bus_sel = 1'b0; use_ws = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HSIZE = 3'd2; HWRITE = 1'b0; HWDATA = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
`ifdef AHB_SRAM_CLEAR_ON_RESET_EN
    model_clear();
`endif

    // Reset values, observed while reset is held.
    #1;
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_resp", 32'(m_resp), 32'd0);
    check("rst_rdata", m_rdata, 32'd0);
    check("rst_ws_ready", 32'(w_ready), 32'd1);
    check("rst_ws_resp", 32'(w_resp), 32'd0);
    check("rst_ws_rdata", w_rdata, 32'd0);
    repeat (3) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);

`ifdef AHB_SRAM_CLEAR_ON_RESET_EN
    issue(1'b1, 1'b0, 17'h14, 3'd2, 32'd0);
    check("clear_word5", act_rdata, 32'h0000_0000);
`endif

    // Word write, byte write into lane 2, then read back with forwarding.
    issue(1'b1, 1'b1, 17'h10, 3'd2, 32'hDEAD_BEEF);
    issue(1'b1, 1'b1, 17'h12, 3'd0, 32'hA555_3C3C);
    issue(1'b1, 1'b0, 17'h10, 3'd2, 32'h0);
    check("byte_merge", act_rdata, 32'hDE55_BEEF);

    // Back-to-back write then read of the same word.
    issue(1'b1, 1'b1, 17'h20, 3'd2, 32'h1234_5678);
    issue(1'b1, 1'b0, 17'h20, 3'd2, 32'h0);
    check("fwd_b2b", act_rdata, 32'h1234_5678);
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    // Fill the randomised region with known data.
    for (int w = 0; w < 64; w++)
      issue(1'b1, 1'b1, 17'(w * 4), 3'd2, $urandom());

    // Directed errors, each followed by a read showing memory unchanged.
    issue(1'b1, 1'b1, 17'h1000, 3'd2, 32'hFFFF_FFFF);
    issue(1'b1, 1'b1, 17'h0003, 3'd1, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 17'h0000, 3'd2, 32'h0);
    issue(1'b1, 1'b1, 17'h0008, 3'd3, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 17'h0008, 3'd2, 32'h0);
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    // Randomised mix of reads, writes, idles and illegal accesses.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 99);
      sz   = 3'($urandom_range(0, 2));
      a    = 17'($urandom_range(0, 255));
      a    = a & ~((17'd1 << sz) - 17'd1);
      if (kind < 6) begin
        sz = 3'd2;
        a  = a | 17'd2;
      end else if (kind < 10) begin
        sz = 3'd3;
      end else if (kind < 14) begin
        a = a + 17'h1000;
      end
      issue(kind < 92, 1'($urandom_range(0, 1)), a, sz, $urandom());
    end
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    // Wait-stated instance: write, then a read whose data holds during waits.
    use_ws = 1'b1;
    issue(1'b1, 1'b1, WS_BASE, 3'd2, 32'h1111_1111);
    issue(1'b1, 1'b0, WS_BASE, 3'd2, 32'h0);
    check("ws_read", act_rdata, 32'h1111_1111);
    issue(1'b1, 1'b0, 17'h0FFC, 3'd2, 32'h0);
    issue(1'b1, 1'b1, 17'h1100, 3'd2, 32'hFFFF_FFFF);
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    // Reset during a wait-stated write: the write must be dropped.
    issue(1'b1, 1'b1, WS_BASE, 3'd2, 32'hCAFE_F00D);
    HWDATA  = 32'hCAFE_F00D;
    bus_sel = 1'b0;
    HTRANS  = 2'b00;
    #2 HRESET = 1'b0;
    #1;
    check("mid_rst_ready", 32'(w_ready), 32'd1);
    check("mid_rst_resp", 32'(w_resp), 32'd0);
    check("mid_rst_rdata", w_rdata, 32'd0);
    check("mid_rst_m_rdata", m_rdata, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESET     = 1'b1;
    pend_valid = 1'b0;
    pend_wdata = '0;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
`ifdef AHB_SRAM_CLEAR_ON_RESET_EN
    model_clear();
`else
    model_write(1'b1, WS_BASE, 3'd2, 32'h1111_1111);
`endif
    @(negedge HCLK);
    issue(1'b1, 1'b0, WS_BASE, 3'd2, 32'h0);
`ifdef AHB_SRAM_CLEAR_ON_RESET_EN
    check("ws_after_rst", act_rdata, 32'h0000_0000);
`else
    check("ws_after_rst", act_rdata, 32'h1111_1111);
`endif
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    // Default instance contents after reset.
    use_ws = 1'b0;
    for (int n = 0; n < 16; n++)
      issue(1'b1, 1'b0, 17'($urandom_range(0, 63) * 4), 3'd2, 32'h0);
    issue(1'b0, 1'b0, 17'h0, 3'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram.md
# ahb_sram

Parametrised AHB-Lite SRAM slave, successor to the 8-bit single-port instruction RAM. It supports configurable data width and depth, byte-lane writes driven by HSIZE, programmable wait states, proper address/data phase pipelining and ERROR responses. It sits on the system AHB-Lite bus behind the decoder and serves as the instruction or data memory for the core.

## Interface
- DATA_W, 32: data bus width; legal values 8, 16, 32, 64.
- ADDR_W, 17: HADDR width.
- DEPTH, 1024: number of DATA_W-bit words.
- BASE_ADDR, 0: byte address of word 0; must be DATA_W/8-aligned.
- WAIT_STATES, 0: extra data-phase cycles per OKAY transfer; legal range 0..7.
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESET  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HWRITE  in  1  1 = write, 0 = read.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase completes only when this is 1.
- HREADYOUT  out  1  slave ready; reset value 1.
- HRESP  out  1  0 = OKAY, 1 = ERROR; reset value 0.
- HRDATA  out  DATA_W  read data, registered; reset value 0.

## Operation
- Accept: HSEL & HTRANS[1] & HREADY at a rising edge. The block latches the address, size, write flag and byte-lane mask and enters the data phase. IDLE and BUSY transfers, or no HSEL, give a zero-wait OKAY with no memory access.
- Word index is (HADDR-BASE_ADDR)/(DATA_W/8). Byte lane is HADDR[log2(DATA_W/8)-1:0]. Byte order is little-endian. The lane mask covers 2^HSIZE bytes starting at that lane.
- Error conditions, any one of which triggers ERROR:
  - HADDR < BASE_ADDR.
  - HADDR >= BASE_ADDR + DEPTH*DATA_W/8.
  - 2^HSIZE > DATA_W/8.
  - HADDR not aligned to 2^HSIZE.
- Error behaviour: the transfer gets the two-cycle ERROR response. No memory write occurs and HRDATA is unchanged.
- Read path: memory is read at the accept edge using the incoming HADDR, and the result is loaded into HRDATA. HRDATA holds its value until the next accepted read.
- Write path: masked bytes of HWDATA are committed at the edge that ends the data phase, when HREADYOUT=1. Unmasked bytes are preserved.
- Read-after-write forwarding: a read may be accepted at the same edge that commits a write to the same word. In that case HRDATA returns the memory word with the written lanes replaced by HWDATA, i.e. the new data.
- State machine, 2-bit:
  - IDLE → DATA on an OKAY-class accept.
  - IDLE → ERR1 on an error accept.
  - DATA → DATA while the wait counter is nonzero.
  - DATA → IDLE or DATA (next accept) when the counter reaches 0.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → IDLE, or to the next accept taken in the same edge.
- Wait counter: loaded with WAIT_STATES on accept and decremented each DATA cycle. HREADYOUT = 0 while the counter is nonzero.
- Reset mid-transfer: state → IDLE, counter cleared, and any pending write dropped. HREADYOUT=1, HRESP=0, HRDATA=0.

## Timing
- Zero-wait OKAY: the address phase is in cycle N, and the data phase in cycle N+1 has HREADYOUT=1. Back-to-back transfers run at one per cycle.
- WAIT_STATES=k: the data phase lasts k+1 cycles, with HREADYOUT low for the first k. HRDATA is valid from the first data-phase cycle and stays stable.
- ERROR: cycle 1 has HREADYOUT=0, HRESP=1. Cycle 2 has HREADYOUT=1, HRESP=1. Wait states are not applied to errors.
- While HREADYOUT=0 no new address phase is accepted, since HREADY=0 on the bus.
- Writes become visible to a read accepted in the same cycle as the commit, through forwarding, and to all later reads.

## Configuration
- AHB_SRAM_CLEAR_ON_RESET_EN
  - Defined: all DEPTH words are zeroed asynchronously on reset.
  - Undefined: memory contents are preserved across reset and reset affects only the control state and outputs. This allows inference as block RAM.

## Test plan
- Reset, default parameters: HREADYOUT=1, HRESP=0, HRDATA=0. With CLEAR_ON_RESET_EN, a read of word 5 returns 0x00000000.
- Word write 0xDEADBEEF @0x10, then byte write 0x55 @0x12 (HSIZE=0) → read @0x10 returns 0xDE55BEEF.
- Back-to-back write 0x12345678 @0x20 followed by read @0x20 in the next address phase → HRDATA=0x12345678 (forwarding).
- WAIT_STATES=2: read @0x0 → HREADYOUT low for 2 cycles, high on the 3rd, with HRDATA valid throughout.
- Error cases, each → HRESP=1 for 2 cycles with HREADYOUT pattern 0,1, and memory unchanged:
  - Access at BASE_ADDR+DEPTH*4.
  - HSIZE=1 at 0x3.
  - HSIZE=3 with DATA_W=32.
- Reset asserted during a wait-stated write → write not committed and outputs return to reset values asynchronously.
